// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clkdiv_pkg
// Purpose : Shared constants and the per-channel configuration record.
// Rev     : 1.0
// ============================================================================
package clkdiv_pkg;

   localparam int CNT_W_DEF  = 16;
   localparam int FACTOR_MIN = 2;
   // Record fields are held at a fixed width; unused upper bits stay zero.
   localparam int CFG_W      = 32;

   typedef logic [CFG_W-1:0] cfg_word_t;

   typedef struct packed {
      cfg_word_t factor;
      cfg_word_t high;
      logic      en;
   } chan_cfg_t;

   function automatic cfg_word_t clamp_factor(input cfg_word_t factor);
      return (factor < cfg_word_t'(FACTOR_MIN)) ? cfg_word_t'(FACTOR_MIN) : factor;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clock_divider_bank_if.sv
`default_nettype none
// ============================================================================
// Module  : clock_divider_bank_if
// Purpose : Configuration write channel of the clock divider bank.
// Rev     : 1.0
// ============================================================================
interface clock_divider_bank_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 16
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_factor;
   logic [CNT_W-1:0] cfg_high;
   logic             cfg_en;

   modport master (
      output cfg_valid, cfg_ch, cfg_factor, cfg_high, cfg_en,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_factor, cfg_high, cfg_en,
      output cfg_ready
   );
endinterface
`default_nettype wire

// File: rtl/clock_divider_channel.sv
`default_nettype none
// ============================================================================
// Module  : clock_divider_channel
// Purpose : One divider: period counter, shadow config applied at wrap, outputs.
// Rev     : 1.0
// ============================================================================
module clock_divider_channel
   import clkdiv_pkg::*;
#(
   parameter int CNT_W          = CNT_W_DEF,
   parameter int DEFAULT_FACTOR = 2
) (
   input  wire            clk_i,
   input  wire            reset,
   input  wire            sync,
   input  wire            wr_en,
   input  wire chan_cfg_t wr_cfg,
   output logic           pending,
   output logic           clk_o,
   output logic           strobe_o
);

   localparam chan_cfg_t c_reset_cfg = '{
      factor : cfg_word_t'(DEFAULT_FACTOR),
      high   : cfg_word_t'(DEFAULT_FACTOR >> 1),
      en     : 1'b1
   };

   logic [CNT_W-1:0] r_count;
   chan_cfg_t        r_cur;
   chan_cfg_t        r_shadow;
   logic             r_pending;
   logic             r_clk;
   logic             r_strobe;

   cfg_word_t        w_count;
   logic             w_last;
   logic             w_apply;
   logic             w_high_phase;

   assign w_count      = cfg_word_t'(r_count);
   assign w_last       = (w_count >= r_cur.factor - cfg_word_t'(1));
   // A disabled channel has no period boundary to wait for.
   assign w_apply      = r_pending && (!r_cur.en || w_last);
   assign w_high_phase = (r_cur.high >= r_cur.factor) ||
                         (w_count >= r_cur.factor - r_cur.high);

   always_ff @(posedge clk_i) begin
      if (reset) begin
         r_count   <= '0;
         r_cur     <= c_reset_cfg;
         r_shadow  <= c_reset_cfg;
         r_pending <= 1'b0;
         r_clk     <= 1'b0;
         r_strobe  <= 1'b0;
      end else begin
         r_clk    <= r_cur.en && w_high_phase;
         r_strobe <= r_cur.en && (r_count == '0);

         if (w_apply) begin
            r_cur     <= r_shadow;
            r_pending <= 1'b0;
         end else if (wr_en && !r_pending) begin
            r_shadow  <= '{factor : clamp_factor(wr_cfg.factor),
                           high   : wr_cfg.high,
                           en     : wr_cfg.en};
            r_pending <= 1'b1;
         end

         if (!r_cur.en || w_apply || sync || w_last) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign pending  = r_pending;
   assign clk_o    = r_clk;
   assign strobe_o = r_strobe;

endmodule
`default_nettype wire

// File: rtl/clock_divider_bank.sv
`default_nettype none
// ============================================================================
// Module  : clock_divider_bank
// Purpose : N_CH independent clock dividers behind one config write port.
//           Define CLKDIV_SYNC_EN to add the sync_i phase-alignment input.
// Rev     : 1.0
// ============================================================================
module clock_divider_bank
   import clkdiv_pkg::*;
#(
   parameter int N_CH           = 4,
   parameter int CNT_W          = CNT_W_DEF,
   parameter int DEFAULT_FACTOR = 2
) (
   input  wire                 clk_i,
   input  wire                 reset,
`ifdef CLKDIV_SYNC_EN
   input  wire                 sync_i,
`endif
   clock_divider_bank_if.slave bus,
   output logic [N_CH-1:0]     clk_o,
   output logic [N_CH-1:0]     strobe_o
);

   logic [N_CH-1:0] w_pending;
   logic [N_CH-1:0] w_wr;
   logic            w_ready;
   logic            w_sync;
   chan_cfg_t       w_cfg;

`ifdef CLKDIV_SYNC_EN
   assign w_sync = sync_i;
`else
   assign w_sync = 1'b0;
`endif

   assign w_cfg = '{factor : cfg_word_t'(bus.cfg_factor),
                    high   : cfg_word_t'(bus.cfg_high),
                    en     : bus.cfg_en};

   // Out-of-range indices stay ready so their writes are consumed and dropped.
   always_comb begin
      w_ready = 1'b1;
      for (int i = 0; i < N_CH; i++) begin
         if (int'(bus.cfg_ch) == i) begin
            w_ready = !w_pending[i];
         end
      end
   end

   assign bus.cfg_ready = w_ready;

   generate
      for (genvar g = 0; g < N_CH; g++) begin : g_ch
         assign w_wr[g] = bus.cfg_valid && w_ready && (int'(bus.cfg_ch) == g);

         clock_divider_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_FACTOR (DEFAULT_FACTOR)
         ) u_ch (
            .clk_i    (clk_i),
            .reset    (reset),
            .sync     (w_sync),
            .wr_en    (w_wr[g]),
            .wr_cfg   (w_cfg),
            .pending  (w_pending[g]),
            .clk_o    (clk_o[g]),
            .strobe_o (strobe_o[g])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_clock_divider_bank
// Purpose : Scoreboard bench: period-waveform reference model vs the DUT.
// Rev     : 1.0
// ============================================================================
module tb_clock_divider_bank;

   localparam int N_CH  = 5;
   localparam int CNT_W = 8;
   localparam int DEF_F = 4;
   localparam int CH_W  = 3;

   logic            clk_i  = 1'b0;
   logic            reset  = 1'b1;
   logic            sync_r = 1'b0;
   logic [N_CH-1:0] clk_o;
   logic [N_CH-1:0] strobe_o;
   int              n_tests = 0;
   int              n_fail  = 0;

   clock_divider_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

   clock_divider_bank #(
      .N_CH           (N_CH),
      .CNT_W          (CNT_W),
      .DEFAULT_FACTOR (DEF_F)
   ) dut (
      .clk_i    (clk_i),
      .reset    (reset),
`ifdef CLKDIV_SYNC_EN
      .sync_i   (sync_r),
`endif
      .bus      (bus),
      .clk_o    (clk_o),
      .strobe_o (strobe_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: each channel holds the {clk,strobe} pattern still to
   // come in its current period; a new pattern is built whenever one starts.
   int       m_factor[N_CH], m_high[N_CH], s_factor[N_CH], s_high[N_CH];
   bit       m_en[N_CH], m_pend[N_CH], s_en[N_CH];
   bit [1:0] m_wave[N_CH][$];

   typedef struct {
      logic [N_CH-1:0] clk;
      logic [N_CH-1:0] stb;
      logic            rdy;
   } exp_t;
   exp_t exp_q[$];

   function automatic void start_period(int ch);
      int low_len;
      m_wave[ch].delete();
      if (!m_en[ch]) return;
      low_len = (m_high[ch] >= m_factor[ch]) ? 0 : m_factor[ch] - m_high[ch];
      for (int k = 0; k < m_factor[ch]; k++) m_wave[ch].push_back({k >= low_len, k == 0});
   endfunction

   always @(posedge clk_i) begin : model
      exp_t     e;
      bit       accept;
      bit       apply;
      int       wch;
      int       f;
      bit [1:0] pos;
      wch    = int'(bus.cfg_ch);
      accept = bus.cfg_valid && ((wch >= N_CH) || !m_pend[wch]);
      e.clk  = '0;
      e.stb  = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (reset) begin
            m_factor[c] = DEF_F;
            m_high[c]   = DEF_F / 2;
            m_en[c]     = 1'b1;
            m_pend[c]   = 1'b0;
            start_period(c);
         end else begin
            if (m_en[c]) begin
               pos      = m_wave[c][0];
               e.clk[c] = pos[1];
               e.stb[c] = pos[0];
            end
            apply = m_pend[c] && (!m_en[c] || m_wave[c].size() == 1);
            if (apply) begin
               m_factor[c] = s_factor[c];
               m_high[c]   = s_high[c];
               m_en[c]     = s_en[c];
               m_pend[c]   = 1'b0;
               start_period(c);
            end else if (m_en[c]) begin
               if (sync_r) begin
                  start_period(c);
               end else begin
                  void'(m_wave[c].pop_front());
                  if (m_wave[c].size() == 0) start_period(c);
               end
            end
         end
      end
      if (!reset && accept && wch < N_CH) begin
         f             = int'(bus.cfg_factor);
         s_factor[wch] = (f < 2) ? 2 : f;
         s_high[wch]   = int'(bus.cfg_high);
         s_en[wch]     = bus.cfg_en;
         m_pend[wch]   = 1'b1;
      end
      #2;
      e.rdy = (int'(bus.cfg_ch) >= N_CH) ? 1'b1 : !m_pend[int'(bus.cfg_ch)];
      exp_q.push_back(e);
   end

   always @(negedge clk_i) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if (clk_o !== e.clk || strobe_o !== e.stb) begin
            n_fail++;
            $display("FAIL outputs t=%0t: clk_o=%b strobe_o=%b, expected clk_o=%b strobe_o=%b",
                     $time, clk_o, strobe_o, e.clk, e.stb);
         end
         n_tests++;
         if (bus.cfg_ready !== e.rdy) begin
            n_fail++;
            $display("FAIL cfg_ready t=%0t ch=%0d: got %b, expected %b",
                     $time, bus.cfg_ch, bus.cfg_ready, e.rdy);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic write_cfg(input int ch, input int f, input int h, input bit en,
                            output int waited);
      bit done;
      done            = 1'b0;
      waited          = 0;
      bus.cfg_valid   = 1'b1;
      bus.cfg_ch      = CH_W'(ch);
      bus.cfg_factor  = CNT_W'(f);
      bus.cfg_high    = CNT_W'(h);
      bus.cfg_en      = en;
      for (int n = 0; n < 64 && !done; n++) begin
         @(negedge clk_i);
         done = bus.cfg_ready;
         if (!done) waited++;
         @(posedge clk_i);
         #1;
      end
      bus.cfg_valid = 1'b0;
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL write_timeout ch=%0d: cfg_ready stayed 0, expected 1 within 64 cycles", ch);
      end
   endtask

   task automatic pulse_sync();
      sync_r = 1'b1;
      step(1);
      sync_r = 1'b0;
   endtask

   initial begin : stimulus
      logic [7:0] cw;
      logic [7:0] sw;
      int         w;
      bus.cfg_valid  = 1'b0;
      bus.cfg_ch     = '0;
      bus.cfg_factor = '0;
      bus.cfg_high   = '0;
      bus.cfg_en     = 1'b0;

      repeat (3) @(posedge clk_i);
      #1 reset = 1'b0;
      check("reset_clk_o", 32'(clk_o), 32'h0);
      check("reset_strobe_o", 32'(strobe_o), 32'h0);
      check("reset_cfg_ready", 32'(bus.cfg_ready), 32'h1);

      // Default factor 4: clk 0,0,1,1 and strobe on the first cycle of each period.
      @(posedge clk_i);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         cw[i] = clk_o[0];
         sw[i] = strobe_o[0];
      end
      check("default_clk_wave", 32'(cw), 32'h0000_00CC);
      check("default_strobe_wave", 32'(sw), 32'h0000_0011);
      @(posedge clk_i);
      #1;

      step(1);
      write_cfg(1, 5, 2, 1'b1, w);
      step(14);

      write_cfg(2, 8, 4, 1'b1, w);
      write_cfg(2, 3, 1, 1'b1, w);
      check("back_to_back_stalled", 32'(w > 0), 32'h1);
      step(12);

      write_cfg(3, 0, 9, 1'b1, w);
      step(10);
      check("factor0_high9_clk", 32'(clk_o[3]), 32'h1);
      write_cfg(3, 0, 9, 1'b0, w);
      step(8);
      check("disabled_clk", 32'(clk_o[3]), 32'h0);
      check("disabled_strobe", 32'(strobe_o[3]), 32'h0);

      write_cfg(6, 3, 1, 1'b1, w);
      check("out_of_range_no_stall", 32'(w), 32'h0);
      step(6);

`ifdef CLKDIV_SYNC_EN
      write_cfg(0, 6, 3, 1'b1, w);
      step(2);
      write_cfg(3, 6, 3, 1'b1, w);
      step(9);
      pulse_sync();
      begin
         int diffs;
         diffs = 0;
         for (int i = 0; i < 14; i++) begin
            @(negedge clk_i);
            if (strobe_o[0] !== strobe_o[3]) diffs++;
         end
         check("sync_strobe_aligned", 32'(diffs), 32'h0);
         @(posedge clk_i);
         #1;
      end
`endif

      for (int it = 0; it < 80; it++) begin
         step($urandom_range(0, 4));
`ifdef CLKDIV_SYNC_EN
         if ($urandom_range(0, 7) == 0) pulse_sync();
`endif
         write_cfg($urandom_range(0, 7), $urandom_range(0, 12), $urandom_range(0, 14),
                   ($urandom_range(0, 4) != 0), w);
      end
      step(20);

      write_cfg(0, 9, 3, 1'b1, w);
      reset = 1'b1;
      bus.cfg_ch = '0;
      step(1);
      reset = 1'b0;
      check("midpending_reset_clk_o", 32'(clk_o), 32'h0);
      check("midpending_reset_strobe_o", 32'(strobe_o), 32'h0);
      check("midpending_reset_ready", 32'(bus.cfg_ready), 32'h1);
      step(20);

      @(negedge clk_i);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
